// File: rtl/decoder_sweep_pkg.sv
// Shared types and helpers for the decoder sweep sequencer.
package decoder_sweep_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int NUM_STEPS = 16;
   localparam int STEP_W    = 4;

   // Steps 0..7 run with the decoder enabled, 8..15 with it disabled.
   function automatic logic [3:0] step_to_code(input logic [STEP_W-1:0] step);
      return {~step[3], step[2:0]};
   endfunction

endpackage

// File: rtl/sweep_hold_counter.sv
// Hold-time counter: counts held cycles of one code and flags the sampling cycle.
module sweep_hold_counter #(
   parameter int HOLD_CYCLES = 10,
   parameter int CNT_W       = $clog2(HOLD_CYCLES)
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic term
);

   logic [CNT_W-1:0] r_cnt;
   logic             w_at_end;

   assign w_at_end = (r_cnt == CNT_W'(HOLD_CYCLES - 1));
   assign term     = w_at_end & en;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (en) begin
         r_cnt <= w_at_end ? '0 : r_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/decoder_sweep_sequencer.sv
// Drives all 16 decoder input codes in turn and captures f1..f3 into truth-table vectors.
// state | meaning
// IDLE  | outputs parked at zero, waiting for start
// RUN   | holding the current code, sampling on the last hold cycle
// DONE  | sweep complete, truth tables valid until the next start
module decoder_sweep_sequencer #(
   parameter int HOLD_CYCLES = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        pause,
   input  logic        abort,
   input  logic        f1,
   input  logic        f2,
   input  logic        f3,
   output logic        e,
   output logic        a,
   output logic        b,
   output logic        c,
   output logic        busy,
   output logic        done,
   output logic [15:0] tt_f1,
   output logic [15:0] tt_f2,
   output logic [15:0] tt_f3
);
   import decoder_sweep_pkg::*;

   localparam int CNT_W = $clog2(HOLD_CYCLES);

   state_t                r_state, w_state_nxt;
   logic [STEP_W-1:0]     r_step, w_step_nxt;
   logic [3:0]            r_code, w_code_nxt;
   logic [NUM_STEPS-1:0]  r_tt_f1, r_tt_f2, r_tt_f3;
   logic                  w_start_ok, w_cnt_en, w_cnt_clr, w_term;

   // abort beats both start and pause
   assign w_start_ok = start & ~abort & (r_state != RUN);
   assign w_cnt_en   = (r_state == RUN) & ~pause & ~abort;
   assign w_cnt_clr  = abort | w_start_ok;

   sweep_hold_counter #(
      .HOLD_CYCLES (HOLD_CYCLES),
      .CNT_W       (CNT_W)
   ) u_hold (
      .clk  (clk),
      .rst  (rst),
      .clr  (w_cnt_clr),
      .en   (w_cnt_en),
      .term (w_term)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_step_nxt  = r_step;
      if (abort) begin
         w_state_nxt = IDLE;
         w_step_nxt  = '0;
      end else if (w_start_ok) begin
         w_state_nxt = RUN;
         w_step_nxt  = '0;
      end else if (w_term) begin
         if (r_step == STEP_W'(NUM_STEPS - 1)) begin
            w_state_nxt = DONE;
            w_step_nxt  = '0;
         end else begin
            w_step_nxt = r_step + STEP_W'(1);
         end
      end
      w_code_nxt = (w_state_nxt == RUN) ? step_to_code(w_step_nxt) : 4'b0000;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_step  <= '0;
         r_code  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_step  <= w_step_nxt;
         r_code  <= w_code_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tt_f1 <= '0;
         r_tt_f2 <= '0;
         r_tt_f3 <= '0;
      end else if (w_start_ok) begin
         r_tt_f1 <= '0;
         r_tt_f2 <= '0;
         r_tt_f3 <= '0;
      end else if (w_term) begin
         r_tt_f1[r_step] <= f1;
         r_tt_f2[r_step] <= f2;
         r_tt_f3[r_step] <= f3;
      end
   end

   assign e     = r_code[3];
   assign a     = r_code[2];
   assign b     = r_code[1];
   assign c     = r_code[0];
   assign busy  = (r_state == RUN);
   assign done  = (r_state == DONE);
   assign tt_f1 = r_tt_f1;
   assign tt_f2 = r_tt_f2;
   assign tt_f3 = r_tt_f3;

endmodule
